pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 7 +
 rtl/if_perf_counter.sv | 15 +
 rtl/pc_fetch_unit.sv | 72 +++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared fetch-stage constants and state encodings.
package pc_fetch_unit_pkg;
  localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [0:0]  ST_FETCH         = 1'b0;
  localparam logic [0:0]  ST_HELD          = 1'b1;
endpackage

// File: rtl/if_perf_counter.sv
// if_perf_counter: 32-bit wrapping event counter with synchronous clear and enable.
module if_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);
  logic [31:0] count_q, count_d;
  always_comb count_d = en ? count_q + 32'd1 : count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch stage with a one-entry hold buffer and deferred redirect.
// Defining IF_PERF_CNT_EN adds FETCH_COUNT / STALL_COUNT outputs.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HOLD,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTRUCTION,
  output logic        IF_BUSYWAIT
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] STALL_COUNT
`endif
);
  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        fetch, mem_done, avail, redirect, drop, advance, defer;
  // In HELD a word is always in hand, so a branch there redirects immediately
  always_comb begin
    fetch      = state_q == ST_FETCH;
    mem_done   = fetch && !IMEM_BUSYWAIT;
    avail      = mem_done || !fetch;
    redirect   = BRANCH_TAKEN && avail;
    drop       = mem_done && pend_q && !redirect;
    advance    = avail && !HOLD && !redirect && !drop;
    defer      = fetch && IMEM_BUSYWAIT && BRANCH_TAKEN;
    pc_d       = redirect ? BRANCH_TARGET : drop ? pend_tgt_q : advance ? pc_q + 32'd4 : pc_q;
    state_d    = (redirect || drop || advance) ? ST_FETCH : mem_done ? ST_HELD : state_q;
    buf_d      = (mem_done && HOLD && !redirect && !drop) ? IMEM_READDATA : buf_q;
    pend_d     = (redirect || drop) ? 1'b0 : defer ? 1'b1 : pend_q;
    pend_tgt_d = defer ? BRANCH_TARGET : pend_tgt_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_VECTOR;
      buf_q      <= NOP_INSTR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
  assign IMEM_ADDRESS   = pc_q;
  assign IF_PC          = pc_q;
  assign IMEM_READ      = !RESET && fetch;
  assign IF_BUSYWAIT    = !RESET && fetch && IMEM_BUSYWAIT;
  assign IF_INSTRUCTION = (RESET || redirect || drop || !avail) ? NOP_INSTR : fetch ? IMEM_READDATA : buf_q;
`ifdef IF_PERF_CNT_EN
  if_perf_counter u_fetch_cnt (.clk(CLK), .rst(RESET), .en(advance), .count(FETCH_COUNT));
  if_perf_counter u_stall_cnt (.clk(CLK), .rst(RESET), .en(IF_BUSYWAIT), .count(STALL_COUNT));
`endif
endmodule
